// File: rtl/manchester_pkg.sv
// Shared Manchester line constants and FSM encoding, common to the receiver and transmitter.
// Window bounds are functions of the half-bit length so each instance can size its own counters.
package manchester_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_HUNT = 2'd1;
   localparam state_t ST_BITS = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   function automatic int win_lo(input int h);
      return (3 * h) / 2;
   endfunction

   function automatic int win_hi(input int h);
      return (5 * h) / 2;
   endfunction

   function automatic int idle_len(input int h);
      return 2 * h;
   endfunction

   function automatic int cnt_width(input int h);
      return $clog2(win_hi(h) + 1);
   endfunction

endpackage

// File: rtl/manchester_rx_line_sync.sv
// Brings the asynchronous serial line into clk: two-flop synchronizer plus one delay flop
// so rising and falling transitions of the synchronized level can be detected.
module line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic line_s_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= line_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign line_s_o = sync_q;
   assign rise_o   = sync_q & ~dly_q;
   assign fall_o   = ~sync_q & dly_q;

endmodule

// File: rtl/manchester_rx.sv
// Manchester (802.3 polarity) receiver: arms after a quiet low line, locks on the sync bit,
// samples each mid-bit transition in a jitter window and hands words out over valid/ready.
module manchester_rx
   import manchester_pkg::*;
#(
   parameter int HALF_CYCLES = 8,
   parameter int DATA_BITS   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 line_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = cnt_width(HALF_CYCLES);
   localparam int IW = $clog2(idle_len(HALF_CYCLES) + 1);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] CNT_LO    = CW'(win_lo(HALF_CYCLES));
   localparam logic [CW-1:0] CNT_HI    = CW'(win_hi(HALF_CYCLES));
   localparam logic [IW-1:0] IDLE_LAST = IW'(idle_len(HALF_CYCLES) - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   logic line_s;
   logic rise;
   logic fall;
   logic edge_s;

   line_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .line_i   (line_in),
      .line_s_o (line_s),
      .rise_o   (rise),
      .fall_o   (fall)
   );

   assign edge_s = rise | fall;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idle_q, idle_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_BITS-1:0]  word_q, word_d;
   logic [DATA_BITS-1:0]  dout_q, dout_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  ovr_q, ovr_d;
   logic                  busy_q, busy_d;

   // cnt_q reads as the number of clocks elapsed since the accepted edge cycle,
   // so an edge seen with cnt_q == 2H sits exactly at its nominal position.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      bit_d   = bit_q;
      word_d  = word_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      ovr_d   = 1'b0;
      busy_d  = busy_q;

      if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (line_s) begin
               idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
               idle_d  = '0;
               state_d = ST_HUNT;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         ST_HUNT: begin
            if (rise) begin
               cnt_d   = CW'(1);
               bit_d   = '0;
               word_d  = '0;
               busy_d  = 1'b1;
               state_d = ST_BITS;
            end
         end
         ST_BITS: begin
            if (cnt_q != CNT_HI) begin
               cnt_d = cnt_q + 1'b1;
            end
            // Edges at or before 1.5H are bit-boundary transitions and fall through.
            if (edge_s && (cnt_q > CNT_LO)) begin
               cnt_d  = CW'(1);
               word_d = DATA_BITS'({word_q, line_s});
               bit_d  = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  state_d = ST_DONE;
               end
            end else if (cnt_q == CNT_HI) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               idle_d  = '0;
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            idle_d  = '0;
            state_d = ST_IDLE;
            if (!valid_q || data_ready) begin
               dout_d  = word_q;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idle_q  <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
      end
   end

   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign frame_err  = err_q;
   assign overrun    = ovr_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_manchester_rx.sv
// Directed bench for manchester_rx: drives Manchester frames cycle by cycle on line_in
// and checks decoded words, handshake, overrun, frame errors, jitter and reset behaviour.
module tb_manchester_rx;

   localparam int H = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       line_in = 1'b0;
   logic       data_ready = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int jit[8];

   int         err_cnt = 0;
   int         ovr_cnt = 0;
   int         dv_cycles = 0;
   int         dv_rises = 0;
   int         busy_cycles = 0;
   logic       dv_prev = 1'b0;
   logic [7:0] last_word = 8'h00;

   manchester_rx #(
      .HALF_CYCLES (H),
      .DATA_BITS   (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .line_in    (line_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Event counters sampled mid-cycle; tasks compare differences across a scenario.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err)  err_cnt++;
         if (overrun)    ovr_cnt++;
         if (busy)       busy_cycles++;
         if (data_valid) begin
            dv_cycles++;
            last_word = data_out;
         end
         if (data_valid && !dv_prev) dv_rises++;
      end
      dv_prev = data_valid;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic hold(input logic lvl, input int n);
      line_in = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_jit();
      for (int i = 0; i < 8; i++) jit[i] = 0;
   endtask

   // Low idle, sync mid-edge, then nbits MSB-first; returns at the last mid-bit transition.
   task automatic send_frame(input int idle, input logic [7:0] d, input int nbits);
      logic prev;
      int   len;
      hold(1'b0, idle);
      prev = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         len = 2 * H + jit[i];
         hold(prev, H);
         hold(~d[7-i], len - H);
         line_in = d[7-i];
         prev = d[7-i];
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      line_in = 1'b0;
      data_ready = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({data_valid, frame_err, overrun, busy} !== 4'b0000)
         $display("FAIL reset_flags: got %b expected 0000", {data_valid, frame_err, overrun, busy});
      tests++;
      if (data_out !== 8'h00)
         $display("FAIL reset_data: got %h expected 00", data_out);
      if (data_out !== 8'h00) fails++;
      if ({data_valid, frame_err, overrun, busy} !== 4'b0000) fails++;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      tests++;
      if ({data_valid, busy} !== 2'b00) begin
         $display("FAIL post_reset_idle: got %b expected 00", {data_valid, busy});
         fails++;
      end
   endtask

   task automatic test_basic();
      int b_err, b_dv, b_busy, lat;
      clear_jit();
      data_ready = 1'b1;
      b_err = err_cnt; b_dv = dv_cycles; b_busy = busy_cycles;
      send_frame(16, 8'hA5, 8);
      lat = -1;
      for (int i = 1; i <= H; i++) begin
         @(negedge clk);
         if (lat < 0 && data_valid === 1'b1) lat = i;
      end
      hold(1'b1, 4);
      #1;
      tests++;
      if (lat !== 4) begin
         $display("FAIL basic_latency: got %0d expected 4", lat); fails++;
      end
      tests++;
      if (last_word !== 8'hA5) begin
         $display("FAIL basic_data: got %h expected a5", last_word); fails++;
      end
      tests++;
      if (dv_cycles - b_dv !== 1) begin
         $display("FAIL basic_valid_cycles: got %0d expected 1", dv_cycles - b_dv); fails++;
      end
      tests++;
      if (err_cnt - b_err !== 0) begin
         $display("FAIL basic_no_err: got %0d expected 0", err_cnt - b_err); fails++;
      end
      tests++;
      if (busy_cycles - b_busy !== 129 || busy !== 1'b0) begin
         $display("FAIL basic_busy: got %0d cycles busy=%b expected 129 busy=0",
                  busy_cycles - b_busy, busy);
         fails++;
      end
   endtask

   task automatic test_overrun();
      int b_ovr, b_rise, b_dv;
      clear_jit();
      data_ready = 1'b0;
      b_ovr = ovr_cnt; b_rise = dv_rises;
      send_frame(16, 8'h3C, 8);
      hold(1'b0, H);
      send_frame(16, 8'hC3, 8);
      hold(1'b1, H + 4);
      #1;
      tests++;
      if (data_valid !== 1'b1 || data_out !== 8'h3C) begin
         $display("FAIL overrun_hold: got valid=%b data=%h expected valid=1 data=3c",
                  data_valid, data_out);
         fails++;
      end
      tests++;
      if (ovr_cnt - b_ovr !== 1) begin
         $display("FAIL overrun_pulse: got %0d expected 1", ovr_cnt - b_ovr); fails++;
      end
      tests++;
      if (dv_rises - b_rise !== 1) begin
         $display("FAIL overrun_rises: got %0d expected 1", dv_rises - b_rise); fails++;
      end
      data_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (data_valid !== 1'b0) begin
         $display("FAIL overrun_accept: got valid=%b expected 0", data_valid); fails++;
      end
      b_dv = dv_cycles;
      send_frame(16, 8'hFF, 8);
      hold(1'b1, H + 4);
      #1;
      tests++;
      if (last_word !== 8'hFF || dv_cycles - b_dv !== 1) begin
         $display("FAIL overrun_next: got data=%h cycles=%0d expected data=ff cycles=1",
                  last_word, dv_cycles - b_dv);
         fails++;
      end
   endtask

   task automatic test_timeout();
      int b_err, b_rise, first, pulses;
      clear_jit();
      data_ready = 1'b1;
      b_err = err_cnt; b_rise = dv_rises;
      send_frame(16, 8'h96, 3);
      first = -1; pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (frame_err === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      tests++;
      if (first !== 23 || pulses !== 1) begin
         $display("FAIL timeout_err: got at %0d x%0d expected at 23 x1", first, pulses); fails++;
      end
      tests++;
      if (busy !== 1'b0 || dv_rises - b_rise !== 0) begin
         $display("FAIL timeout_abort: got busy=%b rises=%0d expected 0 0",
                  busy, dv_rises - b_rise);
         fails++;
      end
      send_frame(16, 8'h96, 8);
      hold(1'b0, H + 4);
      #1;
      tests++;
      if (last_word !== 8'h96 || dv_rises - b_rise !== 1) begin
         $display("FAIL timeout_recover: got data=%h rises=%0d expected 96 1",
                  last_word, dv_rises - b_rise);
         fails++;
      end
      tests++;
      if (err_cnt - b_err !== 1) begin
         $display("FAIL timeout_err_total: got %0d expected 1", err_cnt - b_err); fails++;
      end
   endtask

   task automatic test_jitter();
      int b_err, b_rise;
      for (int i = 0; i < 8; i++) jit[i] = (i % 2 == 0) ? 4 : -3;
      b_err = err_cnt; b_rise = dv_rises;
      send_frame(16, 8'h5A, 8);
      hold(1'b0, H + 4);
      #1;
      tests++;
      if (last_word !== 8'h5A || dv_rises - b_rise !== 1) begin
         $display("FAIL jitter_ok: got data=%h rises=%0d expected 5a 1",
                  last_word, dv_rises - b_rise);
         fails++;
      end
      tests++;
      if (err_cnt - b_err !== 0) begin
         $display("FAIL jitter_no_err: got %0d expected 0", err_cnt - b_err); fails++;
      end
      clear_jit();
      jit[7] = 5;
      b_err = err_cnt; b_rise = dv_rises;
      send_frame(16, 8'h5A, 8);
      hold(1'b0, 2 * H);
      #1;
      tests++;
      if (err_cnt - b_err !== 1 || dv_rises - b_rise !== 0) begin
         $display("FAIL jitter_late: got err=%0d rises=%0d expected 1 0",
                  err_cnt - b_err, dv_rises - b_rise);
         fails++;
      end
      clear_jit();
   endtask

   task automatic test_reset_mid();
      int b_err, b_rise;
      clear_jit();
      b_err = err_cnt; b_rise = dv_rises;
      fork
         begin
            send_frame(16, 8'hFF, 8);
            hold(1'b1, H);
         end
         begin
            repeat (16 + 3 * 2 * H) @(negedge clk);
            tests++;
            if (busy !== 1'b1) begin
               $display("FAIL reset_mid_busy: got %b expected 1", busy); fails++;
            end
            rst_n = 1'b0;
            #1;
            tests++;
            if ({data_valid, frame_err, overrun, busy} !== 4'b0000 || data_out !== 8'h00) begin
               $display("FAIL reset_mid_clear: got flags=%b data=%h expected 0000 00",
                        {data_valid, frame_err, overrun, busy}, data_out);
               fails++;
            end
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end
      join
      #1;
      tests++;
      if (err_cnt - b_err !== 0 || dv_rises - b_rise !== 0) begin
         $display("FAIL reset_mid_ignored: got err=%0d rises=%0d expected 0 0",
                  err_cnt - b_err, dv_rises - b_rise);
         fails++;
      end
      send_frame(16, 8'h81, 8);
      hold(1'b1, H + 4);
      #1;
      tests++;
      if (last_word !== 8'h81 || dv_rises - b_rise !== 1 || err_cnt - b_err !== 0) begin
         $display("FAIL reset_mid_recover: got data=%h rises=%0d err=%0d expected 81 1 0",
                  last_word, dv_rises - b_rise, err_cnt - b_err);
         fails++;
      end
   endtask

   task automatic test_short_idle();
      int b_err, b_rise, b_busy;
      clear_jit();
      b_err = err_cnt; b_rise = dv_rises; b_busy = busy_cycles;
      send_frame(10, 8'hFF, 8);
      hold(1'b1, H + 4);
      #1;
      tests++;
      if (dv_rises - b_rise !== 0 || busy_cycles - b_busy !== 0 || err_cnt - b_err !== 0) begin
         $display("FAIL short_idle_unarmed: got rises=%0d busy=%0d err=%0d expected 0 0 0",
                  dv_rises - b_rise, busy_cycles - b_busy, err_cnt - b_err);
         fails++;
      end
      send_frame(16, 8'hFF, 8);
      hold(1'b1, H + 4);
      #1;
      tests++;
      if (last_word !== 8'hFF || dv_rises - b_rise !== 1) begin
         $display("FAIL short_idle_armed: got data=%h rises=%0d expected ff 1",
                  last_word, dv_rises - b_rise);
         fails++;
      end
   endtask

   initial begin
      clear_jit();
      @(negedge clk);
      test_reset();
      test_basic();
      test_overrun();
      test_timeout();
      test_jitter();
      test_reset_mid();
      test_short_idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
